// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: sequential PC generation, req/gnt instruction memory port,
// 2-entry {pc, instr} buffer to decode, redirect flush. Option macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_FETCH = 2'd1, ST_FLUSH = 2'd2, ST_HALT = 2'd3} state_e;
`else
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_FETCH = 2'd1, ST_FLUSH = 2'd2} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  outst_q, outst_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] s0_pc_q, s0_pc_d, s0_instr_q, s0_instr_d;
    logic [31:0] s1_pc_q, s1_pc_d, s1_instr_q, s1_instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        misalign_q, misalign_d;

    logic        pop_s, req_s, gnt_s, rsp_s, push_s, trap_s, halted_s;
    logic [2:0]  occ_s, inflight_s;
    logic [1:0]  cnt_pop_s;
    logic [31:0] tag_s, tgt_s;

    // A word leaving for decode frees its slot in the same cycle, which is what
    // keeps a 1-cycle memory streaming at one instruction per clock.
    assign pop_s      = (cnt_q != 2'd0) && if_ready;
    assign occ_s      = {1'b0, outst_q} + {1'b0, cnt_q} - {2'b00, pop_s};
    assign req_s      = (state_q == ST_FETCH) && (occ_s < 3'd2);
    assign gnt_s      = req_s && imem_gnt;
    assign rsp_s      = imem_rvalid && (outst_q != 2'd0);
    assign push_s     = (state_q == ST_FETCH) && rsp_s && !redirect;
    // Outstanding requests are consecutive words ending at pc_q-4, so the oldest one is:
    assign tag_s      = pc_q - {28'd0, outst_q, 2'b00};
    assign cnt_pop_s  = cnt_q - {1'b0, pop_s};
    assign inflight_s = {1'b0, outst_q} + {2'b00, gnt_s} - {2'b00, rsp_s};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_s    = redirect_pc;
    assign trap_s   = redirect && (redirect_pc[1:0] != 2'b00);
    assign halted_s = (state_q == ST_HALT);
`else
    assign tgt_s    = redirect_pc & 32'hFFFF_FFFC;
    assign trap_s   = 1'b0;
    assign halted_s = 1'b0;
`endif

    // Next-state logic for the FSM, request counters and the head-first buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        misalign_d = misalign_q;
        s0_pc_d    = s0_pc_q;
        s0_instr_d = s0_instr_q;
        s1_pc_d    = s1_pc_q;
        s1_instr_d = s1_instr_q;

        if (pop_s) begin
            s0_pc_d    = s1_pc_q;
            s0_instr_d = s1_instr_q;
        end else begin
            s0_pc_d    = s0_pc_q;
            s0_instr_d = s0_instr_q;
        end

        if (push_s) begin
            if (cnt_pop_s == 2'd0) begin
                s0_pc_d    = tag_s;
                s0_instr_d = imem_rdata;
            end else begin
                s1_pc_d    = tag_s;
                s1_instr_d = imem_rdata;
            end
        end else begin
            s1_pc_d    = s1_pc_q;
            s1_instr_d = s1_instr_q;
        end
        cnt_d = cnt_pop_s + {1'b0, push_s};

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (gnt_s) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
                outst_d = inflight_s[1:0];
            end
            ST_FLUSH: begin
                if (imem_rvalid && (drop_q != 2'd0)) begin
                    drop_d  = drop_q - 2'd1;
                    state_d = (drop_q == 2'd1) ? ST_FETCH : ST_FLUSH;
                end else begin
                    drop_d  = drop_q;
                    state_d = (drop_q == 2'd0) ? ST_FETCH : ST_FLUSH;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (redirect && !halted_s) begin
            pc_d    = tgt_s;
            cnt_d   = 2'd0;
            outst_d = 2'd0;
            if (trap_s) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_d    = ST_HALT;
`endif
                misalign_d = 1'b1;
                drop_d     = 2'd0;
            end else if (state_q != ST_FLUSH) begin
                drop_d  = inflight_s[1:0];
                state_d = (inflight_s != 3'd0) ? ST_FLUSH : ST_FETCH;
            end else begin
                pc_d = tgt_s;
            end
        end else begin
            misalign_d = misalign_q;
        end

        pcp4_d = s0_pc_d + 32'd4;
    end

    // State and buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            outst_q    <= 2'd0;
            drop_q     <= 2'd0;
            cnt_q      <= 2'd0;
            s0_pc_q    <= RESET_PC;
            s0_instr_q <= NOP;
            s1_pc_q    <= RESET_PC;
            s1_instr_q <= NOP;
            pcp4_q     <= RESET_PC + 32'd4;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            s0_pc_q    <= s0_pc_d;
            s0_instr_q <= s0_instr_d;
            s1_pc_q    <= s1_pc_d;
            s1_instr_q <= s1_instr_d;
            pcp4_q     <= pcp4_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req   = req_s;
    assign imem_addr  = pc_q;
    assign if_valid   = (cnt_q != 2'd0);
    assign if_instr   = s0_instr_q;
    assign if_pc      = s0_pc_q;
    assign if_pcplus4 = pcp4_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with fixed latency, expected
// instruction stream held in a scoreboard queue and compared at each decode handshake.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic        misalign;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pcplus4(if_pcplus4), .misalign(misalign)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { int due; logic [31:0] addr; } rsp_t;

    exp_t exp_q[$];
    rsp_t mem_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   lat = 1;
    int   hs_before;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic seed(input logic [31:0] start, input int n);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: drive inputs and memory response, then observe grant and handshake.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        rsp_t r;
        exp_t e;
        @(negedge clk);
        redirect    = rd;
        redirect_pc = rpc;
        if_ready    = rdy;
        if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        if (imem_req && imem_gnt) begin
            r.due  = cyc + lat;
            r.addr = imem_addr;
            mem_q.push_back(r);
        end
        if (if_valid && if_ready) begin
            hs_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_extra: observed handshake pc %h expected no word", if_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", if_pc, e.pc);
                check("sb_instr", if_instr, e.instr);
                check("sb_pcplus4", if_pcplus4, e.pc + 32'd4);
            end
        end
        if (rd) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) exp_q.delete();
            else seed(rpc, 16);
`else
            seed({rpc[31:2], 2'b00}, 16);
`endif
        end
        cyc++;
    endtask

    task automatic do_reset(input int l);
        @(negedge clk);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_q.delete();
        lat    = l;
        hs_cnt = 0;
        @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_pc", if_pc, RPC);
        check("rst_pcplus4", if_pcplus4, RPC + 32'd4);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
        seed(RPC, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Streaming with 1-cycle memory: boot cycle, first request, one word per clock.
        do_reset(1);
        step(1'b0, 32'h0, 1'b1);
        check("boot_req", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RPC);
        step(1'b0, 32'h0, 1'b1);
        check("c2_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check("stream_valid", 32'(if_valid), 32'd1);
        end
        check("p1_hs", 32'(hs_cnt), 32'd10);

        // Decode stalled: requests stop at two words, head holds, then drains in order.
        do_reset(1);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b0);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(if_valid), 32'd1);
        check("stall_instr", if_instr, mem_word(RPC));
        check("stall_pc", if_pc, RPC);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        check("p2_hs", 32'(hs_cnt), 32'd10);

        // 3-cycle memory, redirect with two requests in flight.
        do_reset(3);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        check("redir_outst2_req", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        check("flush_req_a", 32'(imem_req), 32'd0);
        check("flush_valid", 32'(if_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        check("flush_req_b", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        check("refetch_req", 32'(imem_req), 32'd1);
        check("refetch_addr", imem_addr, 32'h0000_0200);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1);
        check("p3_hs_min", 32'(hs_cnt >= 4), 32'd1);

        // Redirect coinciding with a response and a decode handshake.
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        hs_before = hs_cnt;
        step(1'b1, 32'h0000_0300, 1'b1);
        check("redir_hs_kept", 32'(hs_cnt), 32'(hs_before + 1));
        step(1'b0, 32'h0, 1'b1);
        check("redir_flush_valid", 32'(if_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0300);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // Address wrap at the top of the 32-bit space.
        hs_before = hs_cnt;
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        hs_before = hs_cnt;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        check("wrap_hs_min", 32'(hs_cnt - hs_before >= 4), 32'd1);

        // Misaligned redirect target.
        step(1'b1, 32'h0000_0202, 1'b1);
        hs_before = hs_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        check("trap_misalign", 32'(misalign), 32'd1);
        check("trap_req", 32'(imem_req), 32'd0);
        check("trap_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        check("trap_misalign_hold", 32'(misalign), 32'd1);
        check("trap_req_hold", 32'(imem_req), 32'd0);
        check("trap_valid_hold", 32'(if_valid), 32'd0);
`else
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        check("align_misalign", 32'(misalign), 32'd0);
        check("align_hs_min", 32'(hs_cnt - hs_before >= 4), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
